// File: rtl/crossbar_nxn_rr_if.sv
// Handshake bundle for the N x N round-robin crossbar.
// The slave modport is the crossbar's view. The master modport is the producer/consumer side.
interface crossbar_nxn_rr_if #(
    parameter int N     = 4,
    parameter int WIDTH = 4,
    parameter int SEL_W = 2
);
    logic [N*WIDTH-1:0] in_data;
    logic [N*SEL_W-1:0] in_dest;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic [N*WIDTH-1:0] out_data;
    logic [N*SEL_W-1:0] out_src;
    logic [N-1:0]       out_valid;
    logic [N-1:0]       out_ready;
    logic [N-1:0]       bad_dest;

    modport master (
        output in_data, in_dest, in_valid, out_ready,
        input  in_ready, out_data, out_src, out_valid, bad_dest
    );

    modport slave (
        input  in_data, in_dest, in_valid, out_ready,
        output in_ready, out_data, out_src, out_valid, bad_dest
    );
endinterface

// File: rtl/crossbar_nxn_rr.sv
// Registered N x N crossbar. Each input names its own destination.
// Each output has a one-entry slot and a round-robin arbiter.
module crossbar_nxn_rr #(
    parameter int N     = 4,
    parameter int WIDTH = 4,
    parameter int SEL_W = 2
) (
    input  logic               clk,
    input  logic               rst,
    crossbar_nxn_rr_if.slave   bus
);
    logic [N*WIDTH-1:0] out_data_r;
    logic [N*SEL_W-1:0] out_src_r;
    logic [N-1:0]       out_valid_r;
    logic [N-1:0]       bad_dest_r;
    logic [SEL_W-1:0]   ptr_r [N];

    logic [N-1:0]       dest_ok_s;
    logic [N-1:0]       free_s;
    logic [N-1:0]       gnt_any_s;
    logic [N-1:0]       in_ready_s;
    logic [SEL_W-1:0]   win_s [N];
    logic [SEL_W-1:0]   nxt_ptr_s [N];

    // Flag inputs whose destination index names a real output
    always_comb begin
        dest_ok_s = '0;
        for (int i = 0; i < N; i++) begin
            if (int'(bus.in_dest[i*SEL_W +: SEL_W]) < N) begin
                dest_ok_s[i] = 1'b1;
            end else begin
                dest_ok_s[i] = 1'b0;
            end
        end
    end

    // Per-output round-robin scan starting at the pointer; a draining slot counts as free
    always_comb begin
        logic [SEL_W-1:0] idx_s;
        idx_s      = '0;
        gnt_any_s  = '0;
        in_ready_s = '0;
        free_s     = '0;
        for (int j = 0; j < N; j++) begin
            win_s[j]     = '0;
            nxt_ptr_s[j] = ptr_r[j];
        end
        for (int j = 0; j < N; j++) begin
            free_s[j] = !out_valid_r[j] || bus.out_ready[j];
            for (int k = 0; k < N; k++) begin
                idx_s = SEL_W'((int'(ptr_r[j]) + k) % N);
                if (free_s[j] && !gnt_any_s[j] && bus.in_valid[idx_s] && dest_ok_s[idx_s]
                    && (int'(bus.in_dest[int'(idx_s)*SEL_W +: SEL_W]) == j)) begin
                    gnt_any_s[j]      = 1'b1;
                    win_s[j]          = idx_s;
                    in_ready_s[idx_s] = 1'b1;
                end else begin
                    gnt_any_s[j] = gnt_any_s[j];
                end
            end
            if (int'(win_s[j]) == N - 1) begin
                nxt_ptr_s[j] = '0;
            end else begin
                nxt_ptr_s[j] = win_s[j] + SEL_W'(1);
            end
        end
        if (rst) begin
            in_ready_s = '0;
        end else begin
            in_ready_s = in_ready_s;
        end
    end

    // Output slots, arbiter pointers and bad-destination flags
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_r  <= '0;
            out_src_r   <= '0;
            out_valid_r <= '0;
            bad_dest_r  <= '0;
            for (int j = 0; j < N; j++) begin
                ptr_r[j] <= '0;
            end
        end else begin
            for (int j = 0; j < N; j++) begin
                if (gnt_any_s[j]) begin
                    out_data_r[j*WIDTH +: WIDTH] <= bus.in_data[int'(win_s[j])*WIDTH +: WIDTH];
                    out_src_r[j*SEL_W +: SEL_W]  <= win_s[j];
                    out_valid_r[j]               <= 1'b1;
                    ptr_r[j]                     <= nxt_ptr_s[j];
                end else if (bus.out_ready[j]) begin
                    out_valid_r[j] <= 1'b0;
                end else begin
                    out_valid_r[j] <= out_valid_r[j];
                end
            end
            bad_dest_r <= bus.in_valid & ~dest_ok_s;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_data  = out_data_r;
    assign bus.out_src   = out_src_r;
    assign bus.out_valid = out_valid_r;
    assign bus.bad_dest  = bad_dest_r;
endmodule

// File: tb/tb_crossbar_nxn_rr.sv
// Bench for crossbar_nxn_rr. It uses a 4x4 instance checked against a cycle model.
// A 3-output instance exercises out-of-range destinations.
module tb_crossbar_nxn_rr;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    crossbar_nxn_rr_if #(.N(4), .WIDTH(4), .SEL_W(2)) bus4 ();
    crossbar_nxn_rr_if #(.N(3), .WIDTH(4), .SEL_W(2)) bus3 ();

    crossbar_nxn_rr #(.N(4), .WIDTH(4), .SEL_W(2)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
    crossbar_nxn_rr #(.N(3), .WIDTH(4), .SEL_W(2)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

    int checks = 0;
    int errors = 0;

    // Model state: each output is a slot (valid, data, source) plus its round-robin pointer
    bit   m_valid [4];
    int   m_data  [4];
    int   m_src   [4];
    int   m_ptr   [4];
    logic [3:0] last_rdy;

    typedef struct packed {
        logic [15:0] d;
        logic [7:0]  dest;
        logic [3:0]  v;
        logic [3:0]  ordy;
        logic [3:0]  e_rdy;
        logic [15:0] e_data;
        logic [7:0]  e_src;
        logic [3:0]  e_val;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive4(input logic [15:0] d, input logic [7:0] ds, input logic [3:0] v,
                          input logic [3:0] r);
        bus4.in_data   = d;
        bus4.in_dest   = ds;
        bus4.in_valid  = v;
        bus4.out_ready = r;
    endtask

    // One clock: predict grants from the rules, compare in_ready, advance the model, and compare the outputs
    task automatic tick();
        int w [4];
        int i;
        logic [3:0]  er, v, r, ev;
        logic [15:0] d, eo;
        logic [7:0]  ds, es;
        d = bus4.in_data; ds = bus4.in_dest; v = bus4.in_valid; r = bus4.out_ready;
        er = 4'h0;
        for (int j = 0; j < 4; j++) begin
            w[j] = -1;
            if (!rst && (!m_valid[j] || r[j])) begin
                for (int k = 0; k < 4; k++) begin
                    i = (m_ptr[j] + k) % 4;
                    if (w[j] < 0 && v[i] && int'(ds[i*2 +: 2]) == j) w[j] = i;
                end
            end
            if (w[j] >= 0) er[w[j]] = 1'b1;
        end
        #1;
        last_rdy = bus4.in_ready;
        check("in_ready", 32'(bus4.in_ready), 32'(er));
        @(posedge clk);
        for (int j = 0; j < 4; j++) begin
            if (rst) begin
                m_valid[j] = 1'b0; m_data[j] = 0; m_src[j] = 0; m_ptr[j] = 0;
            end else if (w[j] >= 0) begin
                m_valid[j] = 1'b1;
                m_data[j]  = int'(d[w[j]*4 +: 4]);
                m_src[j]   = w[j];
                m_ptr[j]   = (w[j] + 1) % 4;
            end else if (r[j]) begin
                m_valid[j] = 1'b0;
            end
        end
        #1;
        for (int j = 0; j < 4; j++) begin
            eo[j*4 +: 4] = 4'(m_data[j]);
            es[j*2 +: 2] = 2'(m_src[j]);
            ev[j]        = m_valid[j];
        end
        check("out_valid", 32'(bus4.out_valid), 32'(ev));
        check("out_data",  32'(bus4.out_data),  32'(eo));
        check("out_src",   32'(bus4.out_src),   32'(es));
        check("bad_dest4", 32'(bus4.bad_dest),  32'h0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive4(16'h0, 8'h0, 4'h0, 4'h0);
        tick();
        rst = 1'b0;
    endtask

    initial begin
        vec_t tbl [6];
        logic [3:0] rr_rdy [4];
        logic [3:0] rr_dat [4];
        for (int j = 0; j < 4; j++) begin
            m_valid[j] = 1'b0; m_data[j] = 0; m_src[j] = 0; m_ptr[j] = 0;
        end
        bus3.in_data = 12'h0; bus3.in_dest = 6'h0; bus3.in_valid = 3'h0; bus3.out_ready = 3'h0;

        // Reset with every input requesting and every consumer ready
        rst = 1'b1;
        drive4(16'h4321, 8'hE4, 4'hF, 4'hF);
        tick();
        check("rst_rdy1", 32'(last_rdy), 32'h0);
        tick();
        check("rst_rdy2", 32'(last_rdy), 32'h0);
        check("rst_valid", 32'(bus4.out_valid), 32'h0);
        check("rst_data", 32'(bus4.out_data), 32'h0);
        rst = 1'b0;

        // Vectors from reset: permutation, identity, partial drain, hold, blocked and then granted request
        tbl[0] = '{16'h4321, 8'h1B, 4'hF, 4'hF, 4'hF, 16'h1234, 8'h1B, 4'hF};
        tbl[1] = '{16'h8765, 8'hE4, 4'hF, 4'hF, 4'hF, 16'h8765, 8'hE4, 4'hF};
        tbl[2] = '{16'h0000, 8'h00, 4'h0, 4'h5, 4'h0, 16'h8765, 8'hE4, 4'hA};
        tbl[3] = '{16'h0000, 8'h00, 4'h0, 4'h0, 4'h0, 16'h8765, 8'hE4, 4'hA};
        tbl[4] = '{16'h0900, 8'h10, 4'h4, 4'h0, 4'h0, 16'h8765, 8'hE4, 4'hA};
        tbl[5] = '{16'h0900, 8'h10, 4'h4, 4'h2, 4'h4, 16'h8795, 8'hE8, 4'hA};
        for (int t = 0; t < 6; t++) begin
            drive4(tbl[t].d, tbl[t].dest, tbl[t].v, tbl[t].ordy);
            tick();
            check("tbl_rdy",  32'(last_rdy),       32'(tbl[t].e_rdy));
            check("tbl_data", 32'(bus4.out_data),  32'(tbl[t].e_data));
            check("tbl_src",  32'(bus4.out_src),   32'(tbl[t].e_src));
            check("tbl_val",  32'(bus4.out_valid), 32'(tbl[t].e_val));
        end

        // Round robin: inputs 0,1,2 contend for output 1
        do_reset();
        rr_rdy[0] = 4'h1; rr_rdy[1] = 4'h2; rr_rdy[2] = 4'h4; rr_rdy[3] = 4'h1;
        rr_dat[0] = 4'hA; rr_dat[1] = 4'hB; rr_dat[2] = 4'hC; rr_dat[3] = 4'hA;
        drive4(16'h0CBA, 8'h15, 4'h7, 4'hF);
        for (int t = 0; t < 4; t++) begin
            tick();
            check("rr_rdy",  32'(last_rdy), 32'(rr_rdy[t]));
            check("rr_data", 32'(bus4.out_data[7:4]), 32'(rr_dat[t]));
        end

        // Backpressure: output 2 is full and stalled while input 3 waits
        do_reset();
        drive4(16'h000A, 8'h02, 4'h1, 4'h0);
        tick();
        drive4(16'h5000, 8'h80, 4'h8, 4'h0);
        for (int t = 0; t < 3; t++) begin
            tick();
            check("bp_rdy",  32'(last_rdy[3]), 32'h0);
            check("bp_hold", 32'(bus4.out_data[11:8]), 32'hA);
            check("bp_val",  32'(bus4.out_valid[2]), 32'h1);
        end
        bus4.out_ready = 4'h4;
        tick();
        check("bp_go_rdy", 32'(last_rdy), 32'h8);
        check("bp_go_data", 32'(bus4.out_data[11:8]), 32'h5);
        check("bp_go_src", 32'(bus4.out_src[5:4]), 32'h3);

        // Reset in the middle of stalled contention restarts the pointers
        do_reset();
        drive4(16'h0CBA, 8'h15, 4'h7, 4'hF);
        tick();
        tick();
        bus4.out_ready = 4'h0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("mid_rst_val", 32'(bus4.out_valid), 32'h0);
        rst = 1'b0;
        bus4.out_ready = 4'hF;
        tick();
        check("mid_rst_first", 32'(last_rdy), 32'h1);

        // Out-of-range destination on the 3-output instance
        do_reset();
        bus3.in_valid = 3'b011; bus3.in_dest = 6'b00_11_00; bus3.in_data = 12'h007;
        bus3.out_ready = 3'b000;
        #1;
        check("bad_rdy1", 32'(bus3.in_ready), 32'h1);
        tick();
        check("bad_pulse1", 32'(bus3.bad_dest), 32'h2);
        check("bad_val1", 32'(bus3.out_valid), 32'h1);
        check("bad_data1", 32'(bus3.out_data[3:0]), 32'h7);
        #1;
        check("bad_rdy2", 32'(bus3.in_ready), 32'h0);
        tick();
        check("bad_pulse2", 32'(bus3.bad_dest), 32'h2);
        check("bad_val2", 32'(bus3.out_valid), 32'h1);
        bus3.in_valid = 3'b000;
        tick();
        check("bad_clear", 32'(bus3.bad_dest), 32'h0);

        // Random traffic against the model, with occasional resets
        for (int t = 0; t < 400; t++) begin
            rst = ($urandom_range(0, 49) == 0);
            drive4(16'($urandom), 8'($urandom), 4'($urandom), 4'($urandom));
            tick();
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
